// File: rtl/dmem_arbiter_if.sv
// ============================================================================
// dmem_arbiter_if : bundle of both requester ports and the data-memory bus
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

interface dmem_arbiter_if #(
    parameter int AW = 8,
    parameter int DW = 8
);
    logic          a_req;
    logic          a_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_wdata;
    logic          a_ack;
    logic          a_err;
    logic [DW-1:0] a_rdata;

    logic          b_req;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_ack;
    logic          b_err;
    logic [DW-1:0] b_rdata;

    logic          mem_rm;
    logic          mem_wm;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    // The arbiter side.
    modport slave (
        input  a_req, a_we, a_addr, a_wdata,
        input  b_req, b_we, b_addr, b_wdata,
        input  mem_rdata,
        output a_ack, a_err, a_rdata,
        output b_ack, b_err, b_rdata,
        output mem_rm, mem_wm, mem_addr, mem_wdata
    );

    // Requesters plus the memory itself.
    modport master (
        output a_req, a_we, a_addr, a_wdata,
        output b_req, b_we, b_addr, b_wdata,
        output mem_rdata,
        input  a_ack, a_err, a_rdata,
        input  b_ack, b_err, b_rdata,
        input  mem_rm, mem_wm, mem_addr, mem_wdata
    );
endinterface

`default_nettype wire

// File: rtl/dmem_arbiter.sv
// ============================================================================
// dmem_arbiter : two-port arbiter/sequencer for the 8-bit data memory.
// Optional macro DMEM_ARB_RR_EN selects round-robin instead of fixed priority.
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module dmem_arbiter #(
    parameter int DEPTH = 36,
    parameter int AW    = 8,
    parameter int DW    = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    dmem_arbiter_if.slave  bus
);

    localparam logic [AW:0] DEPTH_W = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t        state;
    state_t        state_next;

    logic          req_any;
    logic          grant_b;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;
    logic          win_oor;

    logic          owner_b;
    logic          we_lat;
    logic          oor_lat;

    assign req_any = bus.a_req | bus.b_req;

`ifdef DMEM_ARB_RR_EN
    logic ptr_b;

    // Pointer hands the next tie to whichever port did not just finish.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_b <= 1'b0;
        end else if (state == DONE) begin
            ptr_b <= ~owner_b;
        end
    end

    assign grant_b = bus.b_req & (~bus.a_req | ptr_b);
`else
    assign grant_b = bus.b_req & ~bus.a_req;
`endif

    always_comb begin
        win_we    = grant_b ? bus.b_we    : bus.a_we;
        win_addr  = grant_b ? bus.b_addr  : bus.a_addr;
        win_wdata = grant_b ? bus.b_wdata : bus.a_wdata;
        win_oor   = ({1'b0, win_addr} >= DEPTH_W);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_any) state_next = ACCESS;
            ACCESS:  state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Strobes, acks and errors default low every cycle so each is a single pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_b       <= 1'b0;
            we_lat        <= 1'b0;
            oor_lat       <= 1'b0;
            bus.mem_rm    <= 1'b0;
            bus.mem_wm    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.a_ack     <= 1'b0;
            bus.b_ack     <= 1'b0;
            bus.a_err     <= 1'b0;
            bus.b_err     <= 1'b0;
            bus.a_rdata   <= '0;
            bus.b_rdata   <= '0;
        end else begin
            bus.mem_rm <= 1'b0;
            bus.mem_wm <= 1'b0;
            bus.a_ack  <= 1'b0;
            bus.b_ack  <= 1'b0;
            bus.a_err  <= 1'b0;
            bus.b_err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_any) begin
                        owner_b       <= grant_b;
                        we_lat        <= win_we;
                        oor_lat       <= win_oor;
                        bus.mem_addr  <= win_addr;
                        bus.mem_wdata <= win_wdata;
                        bus.mem_rm    <= ~win_oor & ~win_we;
                        bus.mem_wm    <= ~win_oor &  win_we;
                    end
                end
                ACCESS: begin
                    if (owner_b) begin
                        bus.b_ack <= 1'b1;
                        bus.b_err <= oor_lat;
                        if (oor_lat)      bus.b_rdata <= '0;
                        else if (!we_lat) bus.b_rdata <= bus.mem_rdata;
                    end else begin
                        bus.a_ack <= 1'b1;
                        bus.a_err <= oor_lat;
                        if (oor_lat)      bus.a_rdata <= '0;
                        else if (!we_lat) bus.a_rdata <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter and access sequencer for the processor's 8-bit data memory. It shares the single combinational read / level-sensitive write memory between the CPU load/store path (port A) and the program loader/debug path (port B). It serialises their requests and drives registered, glitch-free read/write strobes, address and write data to the memory. It returns read data and a completion acknowledge to the winning requester.

## Interface
Parameters:
- DEPTH, 36, number of valid memory locations; addresses >= DEPTH are out of range.
- AW, 8, address width.
- DW, 8, data width.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- a_req, b_req  in  1  request; held high until the matching ack.
- a_we, b_we  in  1  1 = write, 0 = read; stable while req is high.
- a_addr, b_addr  in  AW  address; stable while req is high.
- a_wdata, b_wdata  in  DW  write data; stable while req is high.
- a_ack, b_ack  out  1  one-cycle completion pulse.
- a_err, b_err  out  1  valid with ack; 1 = address out of range.
- a_rdata, b_rdata  out  DW  read data, valid while ack is high; holds its last value otherwise.
- mem_rm  out  1  memory read strobe.
- mem_wm  out  1  memory write strobe.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data, combinational from mem_addr.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - If any request is high, select a winner, latch its we/addr/wdata into mem_addr/mem_wdata and an owner register, then go to ACCESS.
  - If the address is in range, also assert mem_rm (read) or mem_wm (write) for the next cycle.
  - If no request is high, stay in IDLE.
- ACCESS:
  - The strobe is high for exactly this one cycle.
  - On a read, mem_rdata is captured into the owner's rdata register at the end of the cycle.
  - Go to DONE; strobes drop on that edge.
- DONE:
  - The owner's ack is high for one cycle, with err = 1 if the address was out of range.
  - Go to IDLE.
- Out-of-range access (addr >= DEPTH):
  - No strobe is asserted and memory is untouched.
  - ack is given with err = 1; rdata reads 0.
- mem_rm and mem_wm are never high together, and never high outside ACCESS.
- mem_addr and mem_wdata change only on the IDLE→ACCESS edge, so they are stable for the whole strobe.
- Arbitration is evaluated only in IDLE. A request arriving in ACCESS or DONE waits.
- A requester that keeps req high in the cycle after its ack has issued a new transaction.
- The non-owner's ack, err and rdata are unaffected by the other port's transaction.

## Timing
- Reset (rst_n low at a clock edge) forces the following, regardless of state, including mid-ACCESS:
  - state = IDLE; mem_rm = mem_wm = 0; mem_addr = 0; mem_wdata = 0.
  - a_ack = b_ack = 0; a_err = b_err = 0; a_rdata = b_rdata = 0.
  - Priority pointer set to A.
- An interrupted access produces no ack. A write is not guaranteed to have landed.
- Latency: req sampled high in IDLE at edge N → strobe high cycle N+1 → ack high cycle N+2.
- Throughput: one transaction per 3 cycles; 6 cycles for A and B simultaneous.
- Simultaneous requests in IDLE: the winner is decided per Configuration; the loser is served starting at the next IDLE.

## Configuration
- DMEM_ARB_RR_EN defined: round-robin.
  - Pointer starts at A.
  - After a port's transaction completes, the pointer moves to the other port.
  - On a tie, the pointer's port wins.
  - A port requesting alone always wins.
- DMEM_ARB_RR_EN undefined: fixed priority. Port A always wins a tie; port B can be starved by continuous A traffic.

## Test plan
- Reset then single A write: a_req = 1, a_we = 1, addr 5, wdata 0x3C.
  - Required: mem_wm high exactly the next cycle, with mem_addr = 5 and mem_wdata = 0x3C.
  - Required: a_ack the cycle after that, with a_err = 0.
  - Then a B read of addr 5 returns b_rdata = 0x3C with b_ack.
- Simultaneous A and B reads (addr 1 and 2), both held:
  - With DMEM_ARB_RR_EN: order A, B, A, B across 4 transactions, acks 3 cycles apart.
  - Without it: A is served continuously and b_ack never fires while A holds req.
- Out of range: B write to addr 36 (DEPTH = 36).
  - Required: no mem_wm or mem_rm pulse; b_ack with b_err = 1; location 35 unchanged.
  - An A read to addr 200 returns a_err = 1 and a_rdata = 0.
- Reset mid-ACCESS: rst_n low during an A write strobe.
  - Required: next cycle strobes = 0, state IDLE, no a_ack.
  - After release, a new B request is served normally with 2-cycle latency.
- Strobe integrity, random requests over 1000 cycles:
  - mem_rm & mem_wm never both 1.
  - Each strobe lasts 1 cycle, with mem_addr and mem_wdata unchanged during it.
  - Each ack is preceded exactly 2 cycles earlier by the winning req sample.
